sprite_blitter: RTL
===================

# sprite_blitter

Copies one object bitmap from the sprite ROM into the framebuffer at a given screen position, one pixel per clock. It sits directly downstream of the object-id lookup: the caller feeds it the lookup's height, width and ROM base address plus a top-left position, then pulses `start`. Transparent pixels are skipped. With clipping compiled in, off-screen pixels are also skipped.

## Interface
Parameters:
- `SCREEN_W`, default 640: framebuffer width in pixels; also the row stride.
- `SCREEN_H`, default 480: framebuffer height in pixels.
- `COLOR_W`, default 12: pixel width in bits.
- `TRANSPARENT`, default 12'hF0F: key colour that is never written.

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request. Accepted only when `busy`=0.
- `obj_h`  in  11  object height; sampled on accept.
- `obj_w`  in  11  object width; sampled on accept.
- `obj_addr`  in  19  ROM base address of the object; sampled on accept.
- `pos_x`  in  11  top-left x, two's complement; sampled on accept.
- `pos_y`  in  11  top-left y, two's complement; sampled on accept.
- `rom_addr`  out  19  sprite ROM read address.
- `rom_data`  in  COLOR_W  ROM output, valid the cycle after `rom_addr` is presented.
- `fb_we`  out  1  framebuffer write strobe.
- `fb_addr`  out  19  framebuffer address, y*SCREEN_W+x.
- `fb_data`  out  COLOR_W  framebuffer write pixel.
- `busy`  out  1  high while a blit is in progress.
- `done`  out  1  one-cycle pulse when a blit completes.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - On `start`, latch all inputs, clear the row and column counters, set `busy`.
  - If `obj_h`==0 or `obj_w`==0, go to DONE. Otherwise go to RUN.
- RUN:
  - Each cycle, present `rom_addr` = running ROM pointer, then increment the pointer. The pointer starts at `obj_addr` and wraps mod 2^19. No multiplier is used.
  - Column counter counts 0..w-1. On wrap, the row counter increments.
  - The framebuffer pointer starts at pos_y*SCREEN_W+pos_x. It increments per column and advances by SCREEN_W-w+1 on row wrap.
  - A one-stage pipeline register carries the framebuffer address and an in-bounds flag alongside the outstanding ROM read.
  - After issuing pixel (h-1, w-1), go to FLUSH.
- Write rule, in the cycle after issue: `fb_we` = pipeline valid AND in-bounds AND `rom_data` != TRANSPARENT. `fb_data` = `rom_data`.
- FLUSH: retire the last pixel, then go to DONE.
- DONE: `done`=1 and `busy`=0 for one cycle, then go to IDLE. A `start` in this cycle is ignored; the next start is accepted from IDLE.
- Starts while `busy`=1 are ignored.
- `fb_addr`/`fb_data` update every pipeline cycle and are meaningful only while `fb_we`=1.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset mid-blit aborts immediately with no further `fb_we`.
- Cycle 0 is the accept edge. In cycle k (1..w*h), `rom_addr` = obj_addr+k-1.
- The write for pixel k-1 occurs in cycle k+1. Throughput is 1 pixel/clock.
- `done` is high in cycle w*h+2. `busy` is high in cycles 1..w*h+1.
- Zero-size object: `done` is high in cycle 1 and no writes occur.
- Framebuffer address arithmetic is 19-bit and wraps mod 2^19.

## Configuration
- `BLIT_CLIP_EN` defined:
  - `pos_x`/`pos_y` are signed.
  - Pixels with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H have in-bounds=0. They are never written but still take their cycle, so the timing is unchanged.
- `BLIT_CLIP_EN` undefined:
  - Positions are treated as unsigned and in-bounds is always 1.
  - The caller guarantees the object is fully on-screen. Off-screen addresses wrap silently.

## Test plan
- Basic 2x2: h=2, w=2, addr=100, pos=(10,5), all ROM pixels opaque -> `rom_addr` 100,101,102,103 in cycles 1-4. Writes to 3210,3211,3850,3851 in cycles 2-5. `done` in cycle 6.
- Transparency: same blit with ROM[101]=12'hF0F -> exactly 3 writes; 3211 is skipped; `done` still in cycle 6.
- Clip (`BLIT_CLIP_EN`): h=1, w=4, pos=(-2,0) -> writes only to addrs 0 and 1, carrying ROM[base+2] and ROM[base+3]. `done` in cycle 6.
- Zero size: h=0, w=40 -> `done` in cycle 1, no `fb_we`, no `rom_addr` change.
- Start while busy / reset: second `start` at cycle 3 of a 40x40 blit is ignored. Asserting `rst_n`=0 at cycle 10 -> all outputs 0 at once. A fresh start after release completes normally.
- Full box: h=40, w=40, addr=0, pos=(0,0) -> 1600 writes, last `rom_addr` 1599, last `fb_addr` 39*640+39=24999, `done` in cycle 1602.

Source files
------------

// File: rtl/sprite_blitter.sv
// Sprite blitter: streams one object bitmap from the sprite ROM into the framebuffer at one pixel per clock.
// Optional clipping of off-screen pixels is compiled in with `define BLIT_CLIP_EN.
module sprite_blitter #(
    parameter int                 SCREEN_W    = 640,
    parameter int                 SCREEN_H    = 480,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [10:0]        obj_h,
    input  logic [10:0]        obj_w,
    input  logic [18:0]        obj_addr,
    input  logic [10:0]        pos_x,
    input  logic [10:0]        pos_y,
    output logic [18:0]        rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               fb_we,
    output logic [18:0]        fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [10:0] h_q, w_q;
    logic [10:0] row, col;
    logic [18:0] rom_ptr;
    logic [18:0] fb_ptr;
    logic [18:0] row_step;
    logic        p_valid;
    logic        p_inb;
    logic [18:0] p_addr;

    logic [18:0] px_ext, py_ext, fb_start;
    logic        last_col, last_row, last_pix;
    logic        accept, zero_size;
    logic        inb;

    // Handshake: start is a single-cycle request honoured only in IDLE (busy=0);
    // anything presented on start while busy or during the done pulse is dropped.
    assign accept    = (state == S_IDLE) && start;
    assign zero_size = (obj_h == 11'd0) || (obj_w == 11'd0);

`ifdef BLIT_CLIP_EN
    assign px_ext = {{8{pos_x[10]}}, pos_x};
    assign py_ext = {{8{pos_y[10]}}, pos_y};
`else
    assign px_ext = {8'd0, pos_x};
    assign py_ext = {8'd0, pos_y};
`endif

    // Constant-coefficient product, evaluated once per blit; wraps mod 2^19 by width.
    assign fb_start = py_ext * 19'(SCREEN_W) + px_ext;

    assign last_col = (col == w_q - 11'd1);
    assign last_row = (row == h_q - 11'd1);
    assign last_pix = last_col && last_row;

`ifdef BLIT_CLIP_EN
    localparam logic signed [12:0] SW_S = 13'(SCREEN_W);
    localparam logic signed [12:0] SH_S = 13'(SCREEN_H);

    logic signed [12:0] cur_x, cur_y, x0;

    assign inb = (cur_x >= 13'sd0) && (cur_x < SW_S) &&
                 (cur_y >= 13'sd0) && (cur_y < SH_S);

    // Screen coordinates of the pixel being issued, tracked in step with fb_ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x <= '0;
            cur_y <= '0;
            x0    <= '0;
        end else if (accept) begin
            cur_x <= {{2{pos_x[10]}}, pos_x};
            cur_y <= {{2{pos_y[10]}}, pos_y};
            x0    <= {{2{pos_x[10]}}, pos_x};
        end else if (state == S_RUN && !last_pix) begin
            if (last_col) begin
                cur_x <= x0;
                cur_y <= cur_y + 13'sd1;
            end else begin
                cur_x <= cur_x + 13'sd1;
            end
        end
    end
`else
    assign inb = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            h_q      <= '0;
            w_q      <= '0;
            row      <= '0;
            col      <= '0;
            rom_ptr  <= '0;
            fb_ptr   <= '0;
            row_step <= '0;
            p_valid  <= 1'b0;
            p_inb    <= 1'b0;
            p_addr   <= '0;
        end else begin
            p_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        h_q <= obj_h;
                        w_q <= obj_w;
                        row <= '0;
                        col <= '0;
                        if (zero_size) begin
                            state <= S_DONE;
                        end else begin
                            rom_ptr  <= obj_addr;
                            fb_ptr   <= fb_start;
                            row_step <= 19'(SCREEN_W) - {8'd0, obj_w} + 19'd1;
                            state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Carry this pixel's destination alongside its outstanding ROM read.
                    p_valid <= 1'b1;
                    p_addr  <= fb_ptr;
                    p_inb   <= inb;
                    if (last_pix) begin
                        state <= S_FLUSH;
                    end else begin
                        rom_ptr <= rom_ptr + 19'd1;
                        if (last_col) begin
                            col    <= '0;
                            row    <= row + 11'd1;
                            fb_ptr <= fb_ptr + row_step;
                        end else begin
                            col    <= col + 11'd1;
                            fb_ptr <= fb_ptr + 19'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr = rom_ptr;
    assign fb_we    = p_valid && p_inb && (rom_data != TRANSPARENT);
    assign fb_addr  = p_addr;
    assign fb_data  = p_valid ? rom_data : '0;
    assign busy     = (state == S_RUN) || (state == S_FLUSH);
    assign done     = (state == S_DONE);

endmodule
